// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage SRAM access sequencer with pipeline freeze
// Runs one multi-cycle SRAM transfer per request; IDLE -> ACCESS -> DONE -> IDLE.
module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 4,
  parameter int          AW          = 16,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          rd_en_i,
  input  logic          wr_en_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o,
  output logic          ready_o,
  output logic          freeze_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i,
  output logic          sram_we_n_o,
  output logic          sram_oe_n_o
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          is_wr_q;
  logic [AW-1:0] sram_addr_q;
  logic [31:0]   sram_wdata_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          we_n_q;
  logic          oe_n_q;

  logic [31:0]   addr_off;
  logic [AW-1:0] sram_addr_d;
  logic          req;

  assign req         = rd_en_i | wr_en_i;
  assign addr_off    = addr_i - BASE_ADDR;
  assign sram_addr_d = AW'(addr_off >> 2);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_wr_q      <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            // A simultaneous load and store resolves to the store.
            is_wr_q      <= wr_en_i;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= wdata_i;
            cnt_q        <= '0;
            we_n_q       <= ~wr_en_i;
            oe_n_q       <= wr_en_i;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ready_q <= 1'b1;
            if (!is_wr_q) rdata_q <= sram_rdata_i;
          end
        end
        DONE: begin
          // The request is still the same instruction here; never restart.
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign freeze_o     = rst_n_i & (((state_q == IDLE) & req) | (state_q == ACCESS));
  assign rdata_o      = rdata_q;
  assign ready_o      = ready_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_oe_n_o  = oe_n_q;

endmodule
